tron_plot_scheduler: RTL and testbench
======================================

TRON_PLOT_SCHEDULER -- requirements
Module: tron_plot_scheduler

Interface
REQ-001 SHALL have parameter XMAX, default 159, last valid x column.
REQ-002 SHALL have parameter YMAX, default 119, last valid y row.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port clear_req  input  1  request full-screen clear to black.
REQ-006 SHALL have ports p0_req / p1_req  input  1  player n requests one pixel write.
REQ-007 SHALL have ports p0_x / p1_x  input  8  player n pixel column.
REQ-008 SHALL have ports p0_y / p1_y  input  7  player n pixel row.
REQ-009 SHALL have ports p0_colour / p1_colour  input  3  player n pixel colour.
REQ-010 SHALL have ports p0_gnt / p1_gnt  output  1  one-cycle grant; request consumed.
REQ-011 SHALL have port x  output  8  VGA adapter column.
REQ-012 SHALL have port y  output  7  VGA adapter row.
REQ-013 SHALL have port colour  output  3  VGA adapter colour.
REQ-014 SHALL have port plot  output  1  VGA adapter write enable.
REQ-015 SHALL have port busy  output  1  high while in CLEAR.
REQ-016 SHALL have port clear_done  output  1  one-cycle pulse at end of clear.
REQ-017 SHALL have port oor  output  1  one-cycle pulse when a granted coordinate is out of range.

Function
REQ-018 SHALL implement states IDLE, CLEAR, ARB; at most one of p0_gnt/p1_gnt is high in any cycle.
REQ-019 IDLE: clear_req -> CLEAR; else any p*_req -> ARB in the same cycle (combinational grant decision from state IDLE/ARB).
REQ-020 ARB and IDLE both grant; ARB returns to IDLE when no request is pending after a grant.
REQ-021 clear_req SHALL take priority over player requests in IDLE and ARB; no grant issued in the cycle clear is accepted.
REQ-022 Grant rule: single requester granted; both requesting -> round-robin pointer holder granted; pointer moves to the other player after each grant.
REQ-023 Player handshake: req held with stable x/y/colour until gnt; gnt high exactly one cycle per accepted pixel; req may stay high for back-to-back pixels (one grant per cycle max).
REQ-024 Granted x/y/colour SHALL be registered; plot/x/y/colour valid on the cycle after gnt (latency 1).
REQ-025 Granted coordinate with x>XMAX or y>YMAX: gnt still issued, plot held low next cycle, oor pulses that cycle.
REQ-026 CLEAR: sweep y 0..YMAX outer, x 0..XMAX inner, plot=1, colour=000 every cycle; 19200 plot cycles at defaults.
REQ-027 First clear pixel (0,0) SHALL appear on the cycle after clear_req is accepted.
REQ-028 After pixel (XMAX,YMAX) plots, next cycle: clear_done=1, busy=0, state IDLE.
REQ-029 During CLEAR: no grants, player requests wait (not lost), clear_req ignored.
REQ-030 Sweep counters SHALL wrap x to 0 and increment y when x==XMAX; no other counter wrap.
REQ-031 plot=0 in every cycle not covered by REQ-024 or REQ-026.

Reset
REQ-032 resetn low SHALL immediately force: state IDLE, p0_gnt=0, p1_gnt=0, plot=0, x=0, y=0, colour=0, busy=0, clear_done=0, oor=0, round-robin pointer=p0, sweep counters=0.
REQ-033 Reset mid-CLEAR SHALL abort the sweep; after release, no plot until a new clear_req or player request.

Verification
REQ-034 Reset, then p0_req=1 with (10,20,3'b100) -> p0_gnt one cycle; next cycle plot=1, x=10, y=20, colour=100.
REQ-035 p0_req and p1_req both held high 4 cycles from reset -> grants p0,p1,p0,p1; plots follow each grant by 1 cycle.
REQ-036 clear_req pulse -> busy=1, 19200 consecutive plot cycles colour 000 from (0,0) to (159,119), then clear_done=1 one cycle, busy=0.
REQ-037 clear_req and p1_req same cycle -> clear runs first, p1_gnt occurs only after clear_done, its pixel then plots.
REQ-038 p1_req with (160,5) -> p1_gnt issued, next cycle plot=0, oor=1.
REQ-039 resetn driven low at sweep pixel (50,30) -> outputs zero immediately; after release plot stays 0 with no requests.

Source files
------------

// File: rtl/tron_plot_scheduler.sv
// Tron pixel scheduler: arbitrates pixel writes from two players into a single
// VGA adapter write port and performs full-screen clears to black.
module tron_plot_scheduler #(
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear_req,
  input  logic       p0_req,
  input  logic       p1_req,
  input  logic [7:0] p0_x,
  input  logic [7:0] p1_x,
  input  logic [6:0] p0_y,
  input  logic [6:0] p1_y,
  input  logic [2:0] p0_colour,
  input  logic [2:0] p1_colour,
  output logic       p0_gnt,
  output logic       p1_gnt,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       clear_done,
  output logic       oor
);

  localparam logic [7:0] XMAX_L = 8'(XMAX);
  localparam logic [6:0] YMAX_L = 7'(YMAX);

  typedef enum logic [1:0] {IDLE, CLEAR, ARB} state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic       r_rrPtr;
  logic [7:0] r_sx;
  logic [6:0] r_sy;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_oor;
  logic       r_clearDone;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_anyGnt;
  logic       w_clearStart;
  logic       w_sweepLast;
  logic [7:0] w_gntX;
  logic [6:0] w_gntY;
  logic [2:0] w_gntColour;
  logic       w_inRange;

  assign w_sweepLast = (r_state == CLEAR) && (r_sx == XMAX_L) && (r_sy == YMAX_L);
  assign w_anyGnt    = w_gnt0 | w_gnt1;
  assign w_gntX      = w_gnt1 ? p1_x : p0_x;
  assign w_gntY      = w_gnt1 ? p1_y : p0_y;
  assign w_gntColour = w_gnt1 ? p1_colour : p0_colour;
  assign w_inRange   = (w_gntX <= XMAX_L) && (w_gntY <= YMAX_L);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next state and grant decision; a clear request beats any player request
  always_comb begin
    w_nextState  = r_state;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_clearStart = 1'b0;
    case (r_state)
      IDLE, ARB: begin
        if (clear_req) begin
          w_nextState  = CLEAR;
          w_clearStart = 1'b1;
        end else if (p0_req || p1_req) begin
          w_nextState = ARB;
          if (p0_req && (!p1_req || !r_rrPtr)) w_gnt0 = 1'b1;
          else                                 w_gnt1 = 1'b1;
        end else begin
          w_nextState = IDLE;
        end
      end
      CLEAR: begin
        if (w_sweepLast) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Round-robin pointer hands priority to the other player after every grant
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     r_rrPtr <= 1'b0;
    else if (w_gnt0) r_rrPtr <= 1'b1;
    else if (w_gnt1) r_rrPtr <= 1'b0;
  end

  // Clear sweep counters: x inner, y outer, rewound when a clear begins or ends
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (w_clearStart) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (r_state == CLEAR) begin
      if (r_sx == XMAX_L) begin
        r_sx <= '0;
        if (r_sy == YMAX_L) r_sy <= '0;
        else                r_sy <= r_sy + 7'd1;
      end else begin
        r_sx <= r_sx + 8'd1;
      end
    end
  end

  // Granted pixel is captured so it drives the adapter one cycle after the grant
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x         <= '0;
      r_y         <= '0;
      r_colour    <= '0;
      r_plot      <= 1'b0;
      r_oor       <= 1'b0;
      r_clearDone <= 1'b0;
    end else begin
      r_plot      <= w_anyGnt & w_inRange;
      r_oor       <= w_anyGnt & ~w_inRange;
      r_clearDone <= w_sweepLast;
      if (w_anyGnt) begin
        r_x      <= w_gntX;
        r_y      <= w_gntY;
        r_colour <= w_gntColour;
      end
    end
  end

  // Adapter port shows the sweep position while clearing, else the last granted pixel
  always_comb begin
    busy       = (r_state == CLEAR);
    p0_gnt     = w_gnt0;
    p1_gnt     = w_gnt1;
    clear_done = r_clearDone;
    oor        = r_oor;
    if (r_state == CLEAR) begin
      x      = r_sx;
      y      = r_sy;
      colour = 3'b000;
      plot   = 1'b1;
    end else begin
      x      = r_x;
      y      = r_y;
      colour = r_colour;
      plot   = r_plot;
    end
  end

endmodule

// File: tb/tb_tron_plot_scheduler.sv
// Directed self-checking bench for tron_plot_scheduler.
module tb_tron_plot_scheduler;

  logic       clk;
  logic       resetn;
  logic       clear_req;
  logic       p0_req, p1_req;
  logic [7:0] p0_x, p1_x;
  logic [6:0] p0_y, p1_y;
  logic [2:0] p0_colour, p1_colour;
  logic       p0_gnt, p1_gnt;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, clear_done, oor;

  int totalChecks = 0;
  int badChecks   = 0;

  tron_plot_scheduler dut (
    .clk(clk), .resetn(resetn), .clear_req(clear_req),
    .p0_req(p0_req), .p1_req(p1_req),
    .p0_x(p0_x), .p1_x(p1_x), .p0_y(p0_y), .p1_y(p1_y),
    .p0_colour(p0_colour), .p1_colour(p1_colour),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .clear_done(clear_done), .oor(oor)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive both player request ports
  task automatic applyStimulus(input logic r0, input logic [7:0] x0, input logic [6:0] y0,
                               input logic [2:0] c0, input logic r1, input logic [7:0] x1,
                               input logic [6:0] y1, input logic [2:0] c1);
    p0_req = r0; p0_x = x0; p0_y = y0; p0_colour = c0;
    p1_req = r1; p1_x = x1; p1_y = y1; p1_colour = c1;
  endtask

  // Pulse reset low around a negedge and release it
  task automatic applyReset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] allOutputs();
    return 32'({p0_gnt, p1_gnt, plot, x, y, colour, busy, clear_done, oor});
  endfunction

  int  sweepBad;
  logic sawDone, gotGrant, earlyGrant;

  initial begin
    resetn    = 1'b1;
    clear_req = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2 resetn = 1'b0;
    #1 checkOutput("reset outputs", allOutputs(), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Single p0 pixel
    applyStimulus(1, 8'd10, 7'd20, 3'b100, 0, 0, 0, 0);
    #1 checkOutput("p0 gnt", {30'd0, p0_gnt, p1_gnt}, 32'b10);
    @(negedge clk);
    checkOutput("p0 pixel", {plot, x, y, colour}, {1'b1, 8'd10, 7'd20, 3'b100});
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("p0 gnt drop", {30'd0, p0_gnt, p1_gnt}, 32'b00);
    @(negedge clk);
    checkOutput("plot after single", {31'd0, plot}, 32'd0);

    // Both players from reset: alternation p0,p1,p0,p1
    applyReset();
    applyStimulus(1, 8'd1, 7'd11, 3'b001, 1, 8'd2, 7'd22, 3'b010);
    for (int i = 0; i < 4; i++) begin
      #1 checkOutput($sformatf("rr gnt %0d", i), {30'd0, p0_gnt, p1_gnt},
                     (i % 2 == 0) ? 32'b10 : 32'b01);
      @(negedge clk);
      checkOutput($sformatf("rr pixel %0d", i), {plot, x, y},
                  (i % 2 == 0) ? {1'b1, 8'd1, 7'd11} : {1'b1, 8'd2, 7'd22});
      if (i == 3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    end
    #1 checkOutput("rr idle gnt", {30'd0, p0_gnt, p1_gnt}, 32'b00);

    // Full clear sweep
    @(negedge clk);
    clear_req = 1'b1;
    #1 checkOutput("clear accept", {29'd0, p0_gnt, p1_gnt, busy}, 32'd0);
    sweepBad = 0;
    for (int i = 0; i < 19200; i++) begin
      @(negedge clk);
      clear_req = 1'b0;
      if ({plot, busy, colour, x, y} !== {1'b1, 1'b1, 3'b000, 8'(i % 160), 7'(i / 160)})
        sweepBad++;
    end
    checkOutput("sweep bad cycles", 32'(sweepBad), 32'd0);
    @(negedge clk);
    checkOutput("clear done", {29'd0, clear_done, busy, plot}, 32'b100);
    @(negedge clk);
    checkOutput("clear done pulse", {31'd0, clear_done}, 32'd0);

    // Clear and p1 request together: clear wins, p1 waits
    clear_req = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 8'd7, 7'd8, 3'b101);
    #1 checkOutput("clear vs p1 gnt", {30'd0, p0_gnt, p1_gnt}, 32'd0);
    sawDone = 0; gotGrant = 0; earlyGrant = 0;
    for (int k = 0; k < 20000 && !gotGrant; k++) begin
      @(negedge clk);
      clear_req = 1'b0;
      #1;
      if (clear_done) sawDone = 1;
      if (p1_gnt) begin
        gotGrant = 1;
        if (!sawDone || busy) earlyGrant = 1;
      end
    end
    checkOutput("p1 gnt after clear", {29'd0, gotGrant, sawDone, earlyGrant}, 32'b110);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("p1 pixel", {plot, x, y, colour}, {1'b1, 8'd7, 7'd8, 3'b101});

    // Out-of-range and boundary coordinates
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1, 8'd160, 7'd5, 3'b001);
    #1 checkOutput("oor x gnt", {30'd0, p0_gnt, p1_gnt}, 32'b01);
    @(negedge clk);
    applyStimulus(1, 8'd159, 7'd119, 3'b111, 0, 0, 0, 0);
    checkOutput("oor x result", {30'd0, plot, oor}, 32'b01);
    #1 checkOutput("edge gnt", {30'd0, p0_gnt, p1_gnt}, 32'b10);
    @(negedge clk);
    applyStimulus(1, 8'd0, 7'd120, 3'b010, 0, 0, 0, 0);
    checkOutput("edge pixel", {oor, plot, x, y, colour}, {1'b0, 1'b1, 8'd159, 7'd119, 3'b111});
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("oor y result", {30'd0, plot, oor}, 32'b01);
    @(negedge clk);
    checkOutput("oor pulse", {30'd0, plot, oor}, 32'b00);

    // Reset in the middle of a sweep
    clear_req = 1'b1;
    for (int i = 0; i <= 4850; i++) begin
      @(negedge clk);
      clear_req = 1'b0;
    end
    checkOutput("mid sweep pos", {plot, x, y}, {1'b1, 8'd50, 7'd30});
    resetn = 1'b0;
    #1 checkOutput("mid sweep reset", allOutputs(), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    sweepBad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (plot !== 1'b0 || busy !== 1'b0) sweepBad++;
    end
    checkOutput("quiet after reset", 32'(sweepBad), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
